// File: rtl/uart_pkg.sv
// uart_pkg: receiver/transmitter shared state encoding and frame-length constants.
// UART_RX_PARITY_EN adds one even-parity bit to the frame.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
    localparam int START_BITS = 1;
    localparam int STOP_BITS = 1;
`ifdef UART_RX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif
    function automatic int frame_bits(input int data_bits);
        return START_BITS + data_bits + PARITY_BITS + STOP_BITS;
    endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: restartable bit-centre strobe; load_half aligns the first tick to mid start bit.
module uart_baud_tick #(
    parameter int BAUD_DIV = 20
) (
    input  logic clk_in,
    input  logic rst,
    input  logic load_half,
    input  logic enable,
    output logic tick
);
    localparam int W = $clog2(BAUD_DIV);
    logic [W-1:0] cnt;
    assign tick = enable && cnt == '0;
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load_half)
            cnt <= W'(BAUD_DIV / 2 - 1);
        else if (enable)
            cnt <= tick ? W'(BAUD_DIV - 1) : cnt - 1'b1;
    end
endmodule

// File: rtl/uart_rx_controller.sv
// uart_rx_controller: edge-aligned UART receiver with valid/ready byte output.
// Define UART_RX_PARITY_EN for an even-parity bit between data and stop.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = 20,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 parity_err,
    output logic                 busy
);
    localparam int IW = $clog2(DATA_BITS);
    uart_state_t state, state_n;
    logic [1:0] sync;
    logic line, line_d, fall, tick, last_bit, stop_strobe, par_ok, deliver, load;
    logic [IW-1:0] bit_idx;
    logic [DATA_BITS-1:0] shreg;

    assign line        = sync[1];
    assign fall        = line_d & ~line;
    assign busy        = state != IDLE;
    assign last_bit    = bit_idx == IW'(DATA_BITS - 1);
    assign stop_strobe = state == STOP && tick;
    assign deliver     = stop_strobe && line && par_ok;
    assign load        = deliver && (!rx_valid || rx_ready);

`ifdef UART_RX_PARITY_EN
    localparam uart_state_t AFTER_DATA = PARITY;
    logic par_bit;
    assign par_ok = ~(^shreg ^ par_bit);
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bit    <= state == PARITY && tick ? line : par_bit;
            parity_err <= stop_strobe && line && !par_ok;
        end
    end
`else
    localparam uart_state_t AFTER_DATA = STOP;
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
        .clk_in    (clk_in),
        .rst       (rst),
        .load_half (state == IDLE && fall),
        .enable    (busy),
        .tick      (tick)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = fall ? START : IDLE;
            START:   state_n = tick ? (line ? IDLE : DATA) : START;
            DATA:    state_n = tick && last_bit ? AFTER_DATA : DATA;
            PARITY:  state_n = tick ? STOP : PARITY;
            STOP:    state_n = tick ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
    end

    // Stop-bit decision happens at its centre so the next start edge can follow immediately.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync        <= 2'b11;
            line_d      <= 1'b1;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            sync        <= {sync[0], rx_in};
            line_d      <= line;
            bit_idx     <= state == START ? '0 : (state == DATA && tick ? bit_idx + 1'b1 : bit_idx);
            shreg       <= state == DATA && tick ? {line, shreg[DATA_BITS-1:1]} : shreg;
            rx_data     <= load ? shreg : rx_data;
            rx_valid    <= load || (rx_valid && !rx_ready);
            frame_err   <= stop_strobe && !line;
            overrun_err <= deliver && rx_valid && !rx_ready;
        end
    end
endmodule

// File: tb/tb_uart_rx_controller.sv
// tb_uart_rx_controller: directed frames with cycle-exact checks of the receiver outputs.
module tb_uart_rx_controller;
    localparam int BAUD_DIV  = 20;
    localparam int DATA_BITS = 8;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // cycles from driving the start bit to the first cycle rx_valid is visible
    localparam int VLD = 2 + BAUD_DIV / 2 + (FRAME_BITS - 1) * BAUD_DIV + 1;

    logic clk_in = 1'b0, rst = 1'b1, rx_in = 1'b1, rx_ready = 1'b1;
    logic [DATA_BITS-1:0] rx_data;
    logic rx_valid, frame_err, overrun_err, parity_err, busy;
    int checks = 0, errors = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;

    uart_rx_controller #(.BAUD_DIV(BAUD_DIV), .DATA_BITS(DATA_BITS)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .rx_in       (rx_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err),
        .busy        (busy)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (frame_err) fe_cnt++;
        if (overrun_err) ov_cnt++;
        if (parity_err) pe_cnt++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        rx_in = 1'b0;
        wait_cyc(BAUD_DIV);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx_in = d[i];
            wait_cyc(BAUD_DIV);
        end
`ifdef UART_RX_PARITY_EN
        rx_in = par;
        wait_cyc(BAUD_DIV);
`else
        if (par === 1'bx) rx_in = 1'b1;
`endif
        rx_in = stop;
        wait_cyc(BAUD_DIV);
        rx_in = 1'b1;
    endtask

    initial begin
        int fe0, ov0;
        wait_cyc(3);
        chk("rst_valid", 32'(rx_valid), 0);
        chk("rst_data", 32'(rx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_oerr", 32'(overrun_err), 0);
        chk("rst_perr", 32'(parity_err), 0);
        rst = 1'b0;
        wait_cyc(3);

        fork
            send_frame(8'hA5, ^8'hA5, 1'b1);
            begin
                wait_cyc(12);
                chk("a5_busy", 32'(busy), 1);
                wait_cyc(VLD - 13);
                chk("a5_early", 32'(rx_valid), 0);
                wait_cyc(1);
                chk("a5_valid", 32'(rx_valid), 1);
                chk("a5_data", 32'(rx_data), 32'hA5);
                chk("a5_idle", 32'(busy), 0);
                wait_cyc(1);
                chk("a5_1cyc", 32'(rx_valid), 0);
            end
        join

        fe0 = fe_cnt; ov0 = ov_cnt;
        rx_in = 1'b0;
        wait_cyc(5);
        rx_in = 1'b1;
        wait_cyc(6);
        chk("gl_busy", 32'(busy), 1);
        wait_cyc(2);
        chk("gl_drop", 32'(busy), 0);
        wait_cyc(20);
        chk("gl_valid", 32'(rx_valid), 0);
        chk("gl_noerr", 32'(fe_cnt + ov_cnt), 32'(fe0 + ov0));

        fork
            send_frame(8'h3C, ^8'h3C, 1'b0);
            begin
                wait_cyc(VLD);
                chk("fe_pulse", 32'(frame_err), 1);
                chk("fe_novalid", 32'(rx_valid), 0);
                wait_cyc(1);
                chk("fe_1cyc", 32'(frame_err), 0);
            end
        join
        rx_in = 1'b0;
        wait_cyc(40);
        chk("fe_noretrig", 32'(busy), 0);
        chk("fe_count", 32'(fe_cnt - fe0), 1);
        rx_in = 1'b1;
        wait_cyc(5);
        fork
            send_frame(8'h3C, ^8'h3C, 1'b1);
            begin
                wait_cyc(VLD);
                chk("3c_valid", 32'(rx_valid), 1);
                chk("3c_data", 32'(rx_data), 32'h3C);
            end
        join
        wait_cyc(2);

        rx_ready = 1'b0;
        ov0 = ov_cnt;
        fork
            begin
                send_frame(8'h11, ^8'h11, 1'b1);
                send_frame(8'h22, ^8'h22, 1'b1);
            end
            begin
                wait_cyc(VLD);
                chk("ov_first", 32'(rx_data), 32'h11);
                wait_cyc(FRAME_BITS * BAUD_DIV);
                chk("ov_pulse", 32'(overrun_err), 1);
                chk("ov_keep", 32'(rx_data), 32'h11);
                chk("ov_valid", 32'(rx_valid), 1);
                wait_cyc(1);
                chk("ov_1cyc", 32'(overrun_err), 0);
            end
        join
        fork
            send_frame(8'h22, ^8'h22, 1'b1);
            begin
                wait_cyc(VLD - 1);
                rx_ready = 1'b1;
                wait_cyc(1);
                rx_ready = 1'b0;
                chk("rd_valid", 32'(rx_valid), 1);
                chk("rd_data", 32'(rx_data), 32'h22);
                chk("rd_noerr", 32'(overrun_err), 0);
            end
        join
        chk("ov_count", 32'(ov_cnt - ov0), 1);

        fork
            send_frame(8'hFF, ^8'hFF, 1'b1);
            begin
                wait_cyc(52);
                chk("mid_busy", 32'(busy), 1);
                rst = 1'b1;
                #1;
                chk("mr_busy", 32'(busy), 0);
                chk("mr_valid", 32'(rx_valid), 0);
                chk("mr_data", 32'(rx_data), 0);
                wait_cyc(3);
                rst = 1'b0;
            end
        join
        chk("mr_idle", 32'(busy), 0);
        chk("mr_novalid", 32'(rx_valid), 0);
        rx_ready = 1'b1;
        wait_cyc(5);
        fork
            send_frame(8'h5A, ^8'h5A, 1'b1);
            begin
                wait_cyc(VLD);
                chk("5a_valid", 32'(rx_valid), 1);
                chk("5a_data", 32'(rx_data), 32'h5A);
            end
        join
        wait_cyc(5);

`ifdef UART_RX_PARITY_EN
        fork
            send_frame(8'h07, 1'b0, 1'b1);
            begin
                wait_cyc(VLD);
                chk("pe_pulse", 32'(parity_err), 1);
                chk("pe_novalid", 32'(rx_valid), 0);
                wait_cyc(1);
                chk("pe_1cyc", 32'(parity_err), 0);
            end
        join
        wait_cyc(5);
        fork
            send_frame(8'h07, 1'b1, 1'b1);
            begin
                wait_cyc(VLD);
                chk("p7_valid", 32'(rx_valid), 1);
                chk("p7_data", 32'(rx_data), 32'h07);
                chk("p7_noerr", 32'(parity_err), 0);
            end
        join
        wait_cyc(5);
        chk("pe_total", 32'(pe_cnt), 1);
`else
        chk("pe_total", 32'(pe_cnt), 0);
`endif
        chk("fe_total", 32'(fe_cnt), 1);
        chk("ov_total", 32'(ov_cnt), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_controller.md
# uart_rx_controller

Receive-side sequencer for the UART: detects the start bit, times bit-centre samples from a restartable baud-tick sub-block, shifts in the data bits, checks the stop bit and presents each byte on a valid/ready handshake. Sits between the `rx` pad (via its own synchronizer) and the byte consumer. Replaces free-running baud ticking on the receive path with edge-aligned timing.

## Interface
- `BAUD_DIV`, 20, clock cycles per bit; must be even and ≥ 4
- `DATA_BITS`, 8, data bits per frame, 5..9
- `clk_in`  in  1  single clock
- `rst`  in  1  asynchronous, active-high reset
- `rx_in`  in  1  raw serial line, idle high
- `rx_data`  out  DATA_BITS  received byte, LSB = first data bit
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte
- `rx_ready`  in  1  consumer accepts; transfer when `rx_valid && rx_ready`
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0
- `overrun_err`  out  1  one-cycle pulse: frame completed while previous byte unconsumed
- `parity_err`  out  1  one-cycle pulse: parity mismatch (tied 0 without macro)
- `busy`  out  1  state ≠ IDLE

## Operation
- `rx_in` passes a 2-flop synchronizer (reset value 1); falling edge = previous synced 1, current synced 0.
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: on falling edge → START, baud counter loaded for half-bit.
- START: at strobe, synced line 0 → DATA, bit_idx = 0; line 1 → IDLE (glitch, no error flag).
- DATA: each strobe shifts line value in LSB-first; after DATA_BITS strobes → PARITY or STOP.
- STOP: at strobe, always → IDLE (no wait for full stop bit; back-to-back frames supported).
  - line 1, parity OK: deliver byte.
  - line 0: `frame_err` pulse, byte discarded.
- Delivery: if `rx_valid` = 0, or `rx_valid && rx_ready` in the delivery cycle → load `rx_data`, `rx_valid` = 1, no error. Else `overrun_err` pulse, new byte dropped, old `rx_data` kept.
- `rx_valid` clears in the cycle after `rx_valid && rx_ready`, unless reloaded in that same cycle.
- Line held low after a frame error does not retrigger; a new frame requires a fresh falling edge.
- Reset (any time, including mid-frame): state IDLE, partial byte discarded, all outputs 0, counter 0, bit_idx 0.

## Timing
- Sync latency: 2 cycles from pad to edge detect.
- Edge detected in cycle T: START strobe at T + BAUD_DIV/2; each later strobe BAUD_DIV cycles after the previous one.
- STOP strobe at T + BAUD_DIV/2 + (DATA_BITS + 1 [+1 with parity]) × BAUD_DIV.
- `rx_valid` / `frame_err` / `overrun_err` / `parity_err` registered, asserted the cycle after the STOP strobe.
- Counter width: `$clog2(BAUD_DIV)`. The counter does not run in IDLE.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state after DATA; even parity over data bits; mismatch → `parity_err` pulse in the delivery cycle, byte discarded, no `rx_valid`. `frame_err` takes priority if both errors occur.
- Not defined: no PARITY state, `parity_err` tied 0, frame = start + DATA_BITS + stop.

## Structure
- Package `uart_pkg`: state enum (IDLE, START, DATA, PARITY, STOP) and frame-length constants shared with the transmitter.
- Sub-module `uart_baud_tick`: restartable down-counter with inputs `load_half`, `enable` and output `tick`. It reloads `BAUD_DIV-1` on `tick`.

## Test plan
- BAUD_DIV=20, frame 0xA5, `rx_ready`=1 → `rx_data`=0xA5, `rx_valid` for 1 cycle, at T+191 (stop strobe T+190).
- `rx_in` low for 5 cycles only → returns to IDLE, no `rx_valid`, no error pulse, `busy` drops at T+10.
- Frame 0x3C with stop bit 0 → `frame_err` 1-cycle pulse, `rx_valid` stays 0, next falling edge frame 0x3C received normally.
- Back-to-back 0x11, 0x22 with `rx_ready`=0 → `rx_data`=0x11 held, `overrun_err` pulse on second frame. Repeat with `rx_ready` pulsed in the delivery cycle → `rx_data`=0x22, no error.
- `rst` asserted mid-DATA of 0xFF → all outputs 0 immediately, then frame 0x5A → 0x5A received.
- With `UART_RX_PARITY_EN`, 0x07 and parity bit 0 → `parity_err` pulse, no `rx_valid`. Parity bit 1 → 0x07 delivered.
